// File: rtl/fp_mul_unit.sv
// fp_mul_unit: multi-cycle IEEE-754 single-precision multiplier (FMUL.S).
// Captures register-file read operands on start, walks CALC -> NORM -> WB,
// and drives the register-file write port for exactly one cycle.
// Denormal inputs are read as signed zero; tiny results flush to signed zero.
module fp_mul_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_A,
  input  logic [DATA_WIDTH-1:0] op_B,
  input  logic [ADDR_WIDTH-1:0] dest_Addr,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic                  write_En,
  output logic                  flag_NV,
  output logic                  flag_OF,
  output logic                  flag_UF,
  output logic                  flag_NX
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_WB} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_a, r_b;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_sign;
  logic signed [9:0]       r_exp;
  logic [47:0]             r_prod;
  logic                    r_spec;
  logic [31:0]             r_spec_res;
  logic                    r_spec_nv;
  logic                    r_busy, r_we, r_nv, r_of, r_uf, r_nx;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic [ADDR_WIDTH-1:0]   r_waddr;

  // ---- CALC: unpack and classify the captured operands ----
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic        w_snan_a, w_snan_b, w_sign, w_inv, w_spec_nan, w_spec_inf;
  logic        w_spec_zero;
  logic [23:0] w_sig_a, w_sig_b;
  logic [47:0] w_prod;
  logic signed [9:0] w_exp_sum;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_ma     = r_a[22:0];
  assign w_mb     = r_b[22:0];
  // exponent 0 covers both true zero and denormals, which are read as zero
  assign w_zero_a = (w_ea == 8'h00);
  assign w_zero_b = (w_eb == 8'h00);
  assign w_inf_a  = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_inf_b  = (w_eb == 8'hFF) && (w_mb == 23'd0);
  assign w_nan_a  = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_nan_b  = (w_eb == 8'hFF) && (w_mb != 23'd0);
  assign w_snan_a = w_nan_a && !w_ma[22];
  assign w_snan_b = w_nan_b && !w_mb[22];
  assign w_sign   = r_a[31] ^ r_b[31];

  assign w_inv       = (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);
  assign w_spec_nan  = w_nan_a || w_nan_b || w_inv;
  assign w_spec_inf  = w_inf_a || w_inf_b;
  assign w_spec_zero = w_zero_a || w_zero_b;

  assign w_sig_a   = {1'b1, w_ma};
  assign w_sig_b   = {1'b1, w_mb};
  assign w_prod    = {24'd0, w_sig_a} * {24'd0, w_sig_b};
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  // ---- NORM: normalize, round to nearest-even, range check ----
  logic        w_hi, w_g, w_s, w_rnd_up;
  logic [22:0] w_man;
  logic [23:0] w_man_r;
  logic signed [9:0] w_exp_f;
  logic [31:0] w_res;
  logic        w_of, w_uf, w_nx;

  assign w_hi     = r_prod[47];
  assign w_man    = w_hi ? r_prod[46:24] : r_prod[45:23];
  assign w_g      = w_hi ? r_prod[23]    : r_prod[22];
  assign w_s      = w_hi ? |r_prod[22:0] : |r_prod[21:0];
  assign w_rnd_up = w_g && (w_s || w_man[0]);
  // carry out of the 23-bit mantissa leaves w_man_r[22:0] at zero already
  assign w_man_r  = {1'b0, w_man} + {23'd0, w_rnd_up};
  assign w_exp_f  = r_exp + $signed({9'd0, w_hi}) + $signed({9'd0, w_man_r[23]});

  // pick the packed result and flags for the finite (non-special) path
  always_comb begin
    w_res = {r_sign, w_exp_f[7:0], w_man_r[22:0]};
    w_of  = 1'b0;
    w_uf  = 1'b0;
    w_nx  = w_g || w_s;
    if (w_exp_f > 10'sd254) begin
      w_res = {r_sign, 8'hFF, 23'd0};
      w_of  = 1'b1;
      w_nx  = 1'b1;
    end else if (w_exp_f < 10'sd1) begin
      w_res = {r_sign, 31'd0};
      w_uf  = 1'b1;
      w_nx  = 1'b1;
    end
  end

  // control FSM plus every datapath and output register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_addr     <= '0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_prod     <= '0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_spec_nv  <= 1'b0;
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_nv       <= 1'b0;
      r_of       <= 1'b0;
      r_uf       <= 1'b0;
      r_nx       <= 1'b0;
      r_dout     <= '0;
      r_waddr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_A;
            r_b     <= op_B;
            r_addr  <= dest_Addr;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_sign    <= w_sign;
          r_exp     <= w_exp_sum;
          r_prod    <= w_prod;
          r_spec    <= w_spec_nan || w_spec_inf || w_spec_zero;
          r_spec_nv <= w_spec_nan && (w_snan_a || w_snan_b || w_inv);
          if (w_spec_nan)      r_spec_res <= QNAN;
          else if (w_spec_inf) r_spec_res <= {w_sign, 8'hFF, 23'd0};
          else                 r_spec_res <= {w_sign, 31'd0};
          r_state   <= S_NORM;
        end
        S_NORM: begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          if (r_spec) begin
            r_dout <= r_spec_res;
            r_nv   <= r_spec_nv;
            r_of   <= 1'b0;
            r_uf   <= 1'b0;
            r_nx   <= 1'b0;
          end else begin
            r_dout <= w_res;
            r_nv   <= 1'b0;
            r_of   <= w_of;
            r_uf   <= w_uf;
            r_nx   <= w_nx;
          end
          r_state <= S_WB;
        end
        S_WB: begin
          r_we <= 1'b0;
          r_nv <= 1'b0;
          r_of <= 1'b0;
          r_uf <= 1'b0;
          r_nx <= 1'b0;
          // the WB exit edge is the IDLE entry edge, so a start here is taken
          // directly, giving one operation every 3 cycles
          if (start) begin
            r_a     <= op_A;
            r_b     <= op_B;
            r_addr  <= dest_Addr;
            r_state <= S_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign data_out  = r_dout;
  assign writeAddr = r_waddr;
  assign write_En  = r_we;
  assign flag_NV   = r_nv;
  assign flag_OF   = r_of;
  assign flag_UF   = r_uf;
  assign flag_NX   = r_nx;

endmodule
